// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, bit-timing tick constants
// and the default frame width.
package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam logic [3:0] VOTE_T0   = 4'd7;
    localparam logic [3:0] VOTE_T1   = 4'd8;
    localparam logic [3:0] VOTE_T2   = 4'd9;
    localparam logic [3:0] LAST_TICK = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word fall-through byte FIFO with occupancy count and a
// one-cycle overrun pulse when a push is refused on a full buffer.
module uart_byte_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              ovr;
    logic              do_push;
    logic              do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
            ovr <= push && !do_push;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Storage is never cleared, so the head is masked while empty.
    assign rdata   = (cnt != '0) ? mem[rd_ptr] : '0;
    assign ready   = (cnt != '0);
    assign count   = cnt;
    assign overrun = ovr;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority bit voting, break
// handling and a first-word fall-through receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = DEFAULT_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baudclk16,
    input  logic                          rx,
    output logic [DATA_W-1:0]             data,
    output logic                          ready,
    input  logic                          read,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int BW = $clog2(DATA_W);

    logic              sync_p0;
    logic              sync_p1;
    logic              rx_s;
    rx_state_t         state, state_n;
    logic [3:0]        tick, tick_n;
    logic [BW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [1:0]        votes, votes_n;
    logic              bit_val;
    logic              push;
    logic              fe_n;
    logic              fe_q;

    // Stage p0/p1: metastability synchronizer, idles high like the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rx;
            sync_p1 <= sync_p0;
        end
    end
    assign rx_s = sync_p1;

    assign bit_val = majority3(votes[0], votes[1], rx_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            fe_q    <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_cnt <= bit_cnt_n;
            fe_q    <= fe_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        votes <= votes_n;
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        votes_n   = votes;
        push      = 1'b0;
        fe_n      = 1'b0;
        if (baudclk16) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_n = ST_START;
                        tick_n  = '0;
                    end
                end
                ST_START, ST_DATA, ST_STOP: begin
                    tick_n = tick + 4'd1;
                    if (tick == VOTE_T0) votes_n[0] = rx_s;
                    if (tick == VOTE_T1) votes_n[1] = rx_s;
                    if (state == ST_START) begin
                        if (tick == VOTE_T2 && bit_val) begin
                            state_n = ST_IDLE;
                            tick_n  = '0;
                        end else if (tick == LAST_TICK) begin
                            state_n   = ST_DATA;
                            tick_n    = '0;
                            bit_cnt_n = '0;
                        end
                    end else if (state == ST_DATA) begin
                        if (tick == VOTE_T2) shreg_n = {bit_val, shreg[DATA_W-1:1]};
                        if (tick == LAST_TICK) begin
                            if (bit_cnt == BW'(DATA_W-1)) begin
                                state_n = ST_STOP;
                                tick_n  = '0;
                            end else begin
                                bit_cnt_n = bit_cnt + BW'(1);
                            end
                        end
                    end else if (tick == VOTE_T2) begin
                        // Stop bit decides right at the vote; no need to wait out the bit.
                        tick_n = '0;
                        if (bit_val) begin
                            push    = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            fe_n    = 1'b1;
                            state_n = ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_n = ST_IDLE;
                        tick_n  = '0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    tick_n  = '0;
                end
            endcase
        end
    end

    assign frame_err = fe_q;

    uart_byte_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wdata   (shreg_n),
        .pop     (read),
        .rdata   (data),
        .ready   (ready),
        .count   (count),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit-by-bit on a 27-clk
// baudclk16 grid and outputs are compared against hand-computed values.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          baudclk16 = 1'b0;
    logic          rx = 1'b1;
    logic          read = 1'b0;
    logic [DW-1:0] data;
    logic          ready;
    logic          frame_err;
    logic          overrun;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int div = 0;
    int fe0;
    int ov0;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .baudclk16 (baudclk16),
        .rx        (rx),
        .data      (data),
        .ready     (ready),
        .read      (read),
        .frame_err (frame_err),
        .overrun   (overrun),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            baudclk16 = (div == 26);
            div = (div == 26) ? 0 : div + 1;
        end
    end

    always @(posedge clk) begin
        if (frame_err) fe_seen <= fe_seen + 1;
        if (overrun)   ov_seen <= ov_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baudclk16) @(posedge clk);
        end
    endtask

    // mode 0: plain; 1: check push latency; 2: assert read in the push cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low,
                              input int mode, input logic [7:0] exp_head, input int exp_cnt);
        wait_ticks(1);
        #1 rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            wait_ticks(16);
        end
        #1 rx = stop;
        wait_ticks(10);
        if (mode == 1) chk("pre_push_ready", ready, 1'b0);
        if (mode == 2) begin
            forever begin
                @(posedge clk);
                #3;
                if (baudclk16) break;
            end
            read = 1'b1;
            @(posedge clk);
            #1 read = 1'b0;
        end else begin
            wait_ticks(1);
            #1;
        end
        if (mode != 0) begin
            chk("push_ready", ready, 1'b1);
            chk("push_data", data, exp_head);
            chk("push_count", count, exp_cnt);
        end
        wait_ticks(5);
        if (extra_low > 0) wait_ticks(extra_low);
        #1 rx = 1'b1;
    endtask

    task automatic pop_check(input logic [7:0] exp, input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, ready, 1'b1);
        chk(tag, data, exp);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data, 8'h00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_fe", frame_err, 1'b0);
        chk("rst_ov", overrun, 1'b0);
        @(negedge clk) reset = 1'b0;

        // Basic reception with exact push latency, then drain.
        send_frame(8'h55, 1'b1, 0, 1, 8'h55, 1);
        pop_check(8'h55, "pop_55");
        @(negedge clk);
        chk("drain_ready", ready, 1'b0);
        chk("drain_count", count, 0);

        // Read on an empty FIFO is ignored.
        @(negedge clk) read = 1'b1;
        @(negedge clk) read = 1'b0;
        chk("empty_read_count", count, 0);

        // Short low glitch: false start.
        fe0 = fe_seen;
        wait_ticks(1);
        #1 rx = 1'b0;
        wait_ticks(4);
        #1 rx = 1'b1;
        wait_ticks(20);
        chk("false_start_count", count, 0);
        chk("false_start_fe", fe_seen - fe0, 0);

        // Bad stop bit, line held low (break), then recovery.
        fe0 = fe_seen;
        send_frame(8'hA3, 1'b0, 24, 0, 8'h00, 0);
        wait_ticks(2);
        chk("break_fe_pulses", fe_seen - fe0, 1);
        chk("break_count", count, 0);
        send_frame(8'h3C, 1'b1, 0, 2, 8'h3C, 1);
        pop_check(8'h3C, "pop_3C");

        // Fill to full, then one more byte is dropped.
        ov0 = ov_seen;
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1, 0, 0, 8'h00, 0);
        chk("full_count", count, 8);
        send_frame(8'h09, 1'b1, 0, 0, 8'h00, 0);
        chk("overrun_pulses", ov_seen - ov0, 1);
        chk("overrun_count", count, 8);
        chk("overrun_head", data, 8'h01);

        // Push with simultaneous pop on a full FIFO.
        ov0 = ov_seen;
        send_frame(8'h09, 1'b1, 0, 2, 8'h02, 8);
        chk("full_pushpop_ov", ov_seen - ov0, 0);
        for (int i = 2; i <= 9; i++) pop_check(8'(i), "pop_seq");
        @(negedge clk);
        chk("seq_drain_count", count, 0);

        // Reset in the middle of data bit 4 with a byte already queued.
        send_frame(8'h5A, 1'b1, 0, 0, 8'h00, 0);
        chk("pre_reset_count", count, 1);
        wait_ticks(1);
        #1 rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            #1 rx = i[0];
            wait_ticks(16);
        end
        #1 rx = 1'b0;
        wait_ticks(8);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_data", data, 8'h00);
        chk("midrst_ready", ready, 1'b0);
        chk("midrst_count", count, 0);
        chk("midrst_fe", frame_err, 1'b0);
        chk("midrst_ov", overrun, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        wait_ticks(40);
        chk("post_rst_count", count, 0);
        send_frame(8'hC6, 1'b1, 0, 1, 8'hC6, 1);
        pop_check(8'hC6, "pop_C6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
